// File: rtl/gpu_pkg.sv
// rtl/gpu_pkg.sv - shared stream helpers for the gpu stream blocks
package gpu_pkg;

    typedef struct packed {
        logic valid;
        logic ready;
    } gpu_stream_hs_t;

    // Select-index width for an n-way stream select; never narrower than one bit.
    function automatic int gpu_stream_sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/gpu_stream_slot.sv
// rtl/gpu_stream_slot.sv - one-entry registered stream slot with same-cycle refill
module gpu_stream_slot #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_load,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_space
);

    // A full slot that drains this cycle can accept a new beat on the same edge.
    assign o_space = !o_valid || i_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid <= 1'b0;
            o_data  <= '0;
        end else if (i_load) begin
            o_valid <= 1'b1;
            o_data  <= i_data;
        end else if (i_ready) begin
            o_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/gpu_stream_demux_n.sv
// rtl/gpu_stream_demux_n.sv - 1:N valid/ready stream demux with broadcast and registered outputs
module gpu_stream_demux_n
    import gpu_pkg::*;
#(
    parameter int NUM_OUTPUTS = 4,
    parameter int DATA_WIDTH  = 32,
    parameter int SEL_W       = gpu_stream_sel_w(NUM_OUTPUTS)
) (
    input  logic                                   i_clk,
    input  logic                                   i_rst_n,
    input  logic                                   i_valid,
    output logic                                   o_ready,
    input  logic [DATA_WIDTH-1:0]                  i_data,
    input  logic [SEL_W-1:0]                       i_dest,
    input  logic                                   i_bcast,
    output logic [NUM_OUTPUTS-1:0]                 o_valid,
    input  logic [NUM_OUTPUTS-1:0]                 i_ready,
    output logic [NUM_OUTPUTS-1:0][DATA_WIDTH-1:0] o_data,
    output logic                                   o_idle
);

    if ((NUM_OUTPUTS < 2) || ((NUM_OUTPUTS & (NUM_OUTPUTS - 1)) != 0)) begin : g_bad_num_outputs
        $fatal(1, "gpu_stream_demux_n: NUM_OUTPUTS must be a power of two >= 2");
    end

    logic [NUM_OUTPUTS-1:0] target;
    logic [NUM_OUTPUTS-1:0] space;
    logic [NUM_OUTPUTS-1:0] load;
    logic                   acc;

    always_comb begin
        target = '0;
        if (i_bcast) begin
            target = '1;
        end else begin
            target[i_dest] = 1'b1;
        end
    end

    // Broadcast waits for every slot at once so a beat is never split across outputs.
    assign o_ready = i_bcast ? &space : space[i_dest];
    assign acc     = i_valid && o_ready;
    assign load    = {NUM_OUTPUTS{acc}} & target;
    assign o_idle  = ~|o_valid;

    for (genvar k = 0; k < NUM_OUTPUTS; k++) begin : g_slot
        gpu_stream_slot #(
            .DATA_WIDTH(DATA_WIDTH)
        ) u_slot (
            .i_clk  (i_clk),
            .i_rst_n(i_rst_n),
            .i_load (load[k]),
            .i_data (i_data),
            .o_valid(o_valid[k]),
            .i_ready(i_ready[k]),
            .o_data (o_data[k]),
            .o_space(space[k])
        );
    end

endmodule

// File: tb/tb_gpu_stream_demux_n.sv
// tb/tb_gpu_stream_demux_n.sv - directed and scoreboard bench for gpu_stream_demux_n
module tb_gpu_stream_demux_n;

    localparam int N  = 4;
    localparam int DW = 32;

    logic              i_clk = 1'b0;
    logic              i_rst_n;
    logic              i_valid;
    logic              o_ready;
    logic [DW-1:0]     i_data;
    logic [1:0]        i_dest;
    logic              i_bcast;
    logic [N-1:0]      o_valid;
    logic [N-1:0]      i_ready;
    logic [N-1:0][DW-1:0] o_data;
    logic              o_idle;

    int n_checks = 0;
    int n_errors = 0;

    always #5 i_clk = ~i_clk;

    gpu_stream_demux_n #(
        .NUM_OUTPUTS(N),
        .DATA_WIDTH (DW)
    ) dut (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_valid(i_valid),
        .o_ready(o_ready),
        .i_data (i_data),
        .i_dest (i_dest),
        .i_bcast(i_bcast),
        .o_valid(o_valid),
        .i_ready(i_ready),
        .o_data (o_data),
        .o_idle (o_idle)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    logic [DW-1:0] q[N][$];

    initial begin
        int          sent;
        int          cyc;
        logic        acc_now;
        logic        stall[N];
        logic [DW-1:0] held[N];
        logic [DW-1:0] exp;

        i_rst_n = 1'b0;
        i_valid = 1'b0;
        i_data  = '0;
        i_dest  = '0;
        i_bcast = 1'b0;
        i_ready = '0;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        step();

        // Reset state
        check("rst_valid", 32'(o_valid), 32'h0);
        check("rst_idle",  32'(o_idle), 32'h1);
        check("rst_data2", o_data[2], 32'h0);
        check("rst_ready", 32'(o_ready), 32'h1);

        // 1: single beat to dest 2
        i_ready = 4'hF;
        i_valid = 1'b1; i_dest = 2'd2; i_data = 32'hA5A5_0001;
        step();
        i_valid = 1'b0;
        check("t1_valid", 32'(o_valid), 32'h4);
        check("t1_data2", o_data[2], 32'hA5A5_0001);
        check("t1_idle",  32'(o_idle), 32'h0);
        step();
        check("t1_valid_after", 32'(o_valid), 32'h0);
        check("t1_idle_after",  32'(o_idle), 32'h1);

        // 2: refill-while-drain on dest 1
        i_ready = 4'b1101;
        i_valid = 1'b1; i_dest = 2'd1; i_data = 32'hB000_0001;
        #1;
        check("t2_ready_first", 32'(o_ready), 32'h1);
        step();
        check("t2_valid_first", 32'(o_valid), 32'h2);
        check("t2_data_first",  o_data[1], 32'hB000_0001);
        i_data = 32'hB000_0002;
        #1;
        check("t2_ready_blocked", 32'(o_ready), 32'h0);
        step();
        check("t2_data_hold",  o_data[1], 32'hB000_0001);
        check("t2_valid_hold", 32'(o_valid), 32'h2);
        i_ready = 4'hF;
        #1;
        check("t2_ready_drain", 32'(o_ready), 32'h1);
        step();
        i_valid = 1'b0;
        check("t2_data_second",  o_data[1], 32'hB000_0002);
        check("t2_valid_second", 32'(o_valid), 32'h2);
        step();
        check("t2_valid_empty", 32'(o_valid), 32'h0);

        // 3: broadcast blocked by stalled slot 3
        i_ready = 4'b0111;
        i_valid = 1'b1; i_dest = 2'd3; i_data = 32'hC000_0003;
        step();
        check("t3_valid_fill", 32'(o_valid), 32'h8);
        i_bcast = 1'b1; i_data = 32'hDDDD_DDDD; i_dest = 2'd0;
        #1;
        check("t3_ready_blocked", 32'(o_ready), 32'h0);
        step();
        check("t3_valid_blocked", 32'(o_valid), 32'h8);
        check("t3_data0_untouched", o_data[0], 32'h0);
        check("t3_data3_held", o_data[3], 32'hC000_0003);
        i_ready = 4'hF;
        #1;
        check("t3_ready_open", 32'(o_ready), 32'h1);
        step();
        i_valid = 1'b0; i_bcast = 1'b0;
        check("t3_valid_all", 32'(o_valid), 32'hF);
        for (int k = 0; k < N; k++) check("t3_data_bcast", o_data[k], 32'hDDDD_DDDD);
        step();
        check("t3_valid_empty", 32'(o_valid), 32'h0);

        // 4: streaming 100 beats with random backpressure
        sent = 0;
        cyc  = 0;
        while (cyc < 3000 && (sent < 100 || !o_idle)) begin
            cyc++;
            i_ready = (sent < 100) ? 4'($urandom) : 4'hF;
            if (!i_valid && sent < 100 && $urandom_range(0, 3) != 0) begin
                i_valid = 1'b1;
                i_dest  = 2'(sent % N);
                i_data  = 32'h4000_0000 + 32'(sent);
            end
            #1;
            acc_now = i_valid && o_ready;
            if (acc_now) q[i_dest].push_back(i_data);
            for (int k = 0; k < N; k++) begin
                if (o_valid[k] && i_ready[k]) begin
                    if (q[k].size() == 0) begin
                        check("t4_unexpected_beat", o_data[k], 32'hFFFF_FFFF);
                    end else begin
                        exp = q[k].pop_front();
                        check("t4_stream_data", o_data[k], exp);
                    end
                end
                stall[k] = o_valid[k] && !i_ready[k];
                held[k]  = o_data[k];
            end
            @(posedge i_clk);
            #1;
            for (int k = 0; k < N; k++) begin
                if (stall[k]) begin
                    check("t4_stable_data",  o_data[k], held[k]);
                    check("t4_stable_valid", 32'(o_valid[k]), 32'h1);
                end
            end
            if (acc_now) begin
                i_valid = 1'b0;
                sent++;
            end
        end
        check("t4_sent", 32'(sent), 32'd100);
        for (int k = 0; k < N; k++) check("t4_leftover", 32'(q[k].size()), 32'h0);

        // 5: async reset with three slots full
        i_ready = 4'h0;
        for (int k = 0; k < 3; k++) begin
            i_valid = 1'b1; i_dest = 2'(k); i_data = 32'hE000_0000 + 32'(k);
            step();
        end
        i_valid = 1'b0;
        check("t5_valid_full", 32'(o_valid), 32'h7);
        #2;
        i_rst_n = 1'b0;
        #1;
        check("t5_valid_async", 32'(o_valid), 32'h0);
        check("t5_idle_async",  32'(o_idle), 32'h1);
        check("t5_data_async",  o_data[0], 32'h0);
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        i_ready = 4'hF;
        for (int c = 0; c < 3; c++) begin
            step();
            check("t5_no_stale", 32'(o_valid), 32'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
